// File: rtl/dot_matrix_anim_pkg.sv
// Shared widths, idle row pattern and sequencer mode type for the dot-matrix animation driver.
package dot_matrix_pkg;

    localparam int SUBSLOTS = 16;
    localparam logic [63:0] ROW_IDLE_N = '1;

    typedef enum logic {SEQ_LOOP, SEQ_ONESHOT} seq_mode_e;

    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int frame_w(input int frames);
        return clog2_min1(frames);
    endfunction

    function automatic int row_w(input int rows);
        return clog2_min1(rows);
    endfunction

endpackage

// File: rtl/dot_matrix_anim_frame_ram.sv
// Frame bitmap store: one write port and one registered read port, no reset on the array.
module dm_frame_ram
    import dot_matrix_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 16,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // A read of the address being written returns the previous contents.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/dot_matrix_anim.sv
// Row-multiplexed bi-colour LED matrix scanner with a tick-driven frame sequencer.
// Optional DMA_PWM_DIM_EN adds a 4-bit brightness input that gates columns per 1/16 sub-slot.
module dot_matrix_anim
    import dot_matrix_pkg::*;
#(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int FRAMES      = 4,
    parameter int SCAN_DIV    = 1,
    parameter int FRAME_TICKS = 1000,
    localparam int FW = frame_w(FRAMES),
    localparam int RW = row_w(ROWS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            advance,
    input  logic            oneshot,
    input  logic            wr_en,
    input  logic [FW-1:0]   wr_frame,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_red,
    input  logic [COLS-1:0] wr_green,
`ifdef DMA_PWM_DIM_EN
    input  logic [3:0]      bright,
`endif
    output logic [ROWS-1:0] row_n,
    output logic [COLS-1:0] col_red,
    output logic [COLS-1:0] col_green,
    output logic [FW-1:0]   frame_idx,
    output logic            seq_done
);

    localparam int DEPTH = FRAMES * ROWS;
    localparam int AW    = clog2_min1(DEPTH);
    localparam int DW    = clog2_min1(SCAN_DIV);
    localparam int TW    = clog2_min1(FRAME_TICKS);

    localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
    localparam logic [DW-1:0] LAST_DIV   = DW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] LAST_TICK  = TW'(FRAME_TICKS - 1);

    logic [RW-1:0]   r_q, r_d;
    logic [DW-1:0]   div_q, div_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            pending_q, pending_d;
    logic            reached_q, reached_d;
    logic [ROWS-1:0] row_n_q, row_n_d;
    logic            show_q, show_d;
    logic [FW-1:0]   frame_idx_q, frame_idx_d;
    logic            seq_done_q, seq_done_d;
`ifdef DMA_PWM_DIM_EN
    localparam logic [3:0] SUB_LAST = 4'(SUBSLOTS - 1);
    logic [3:0]      sub_q, sub_d;
`endif

    seq_mode_e       mode;
    logic            div_wrap, slot_end, row_wrap, tick, step, rd_en, wr_ok;
    logic [AW-1:0]   rd_addr, wr_addr;
    logic [2*COLS-1:0] rd_data;

    assign wr_ok   = wr_en && (int'(wr_frame) < FRAMES) && (int'(wr_row) < ROWS);
    assign wr_addr = AW'(wr_frame) * AW'(ROWS) + AW'(wr_row);
    assign rd_addr = AW'(frame_q) * AW'(ROWS) + AW'(r_q);

    dm_frame_ram #(
        .DEPTH (DEPTH),
        .WIDTH (2 * COLS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata ({wr_red, wr_green}),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Defaults are the blanked run=0 state; frame steps only land on the row wrap so frames never tear.
    always_comb begin
        mode     = oneshot ? SEQ_ONESHOT : SEQ_LOOP;
        div_wrap = (div_q == LAST_DIV);
`ifdef DMA_PWM_DIM_EN
        slot_end = div_wrap && (sub_q == SUB_LAST);
        rd_en    = run && (div_q == '0) && (sub_q == '0);
`else
        slot_end = div_wrap;
        rd_en    = run && (div_q == '0);
`endif
        row_wrap = slot_end && (r_q == LAST_ROW);
        tick     = (tick_q == LAST_TICK);
        step     = pending_q || (tick && advance);

        r_d         = '0;
        div_d       = '0;
        tick_d      = '0;
        frame_d     = '0;
        pending_d   = 1'b0;
        reached_d   = 1'b0;
        row_n_d     = ROW_IDLE_N[ROWS-1:0];
        show_d      = 1'b0;
        frame_idx_d = '0;
        seq_done_d  = 1'b0;
`ifdef DMA_PWM_DIM_EN
        sub_d       = '0;
`endif

        if (run) begin
            div_d     = div_wrap ? '0 : div_q + DW'(1);
            r_d       = slot_end ? (row_wrap ? '0 : r_q + RW'(1)) : r_q;
            tick_d    = tick ? '0 : tick_q + TW'(1);
            pending_d = step;
            frame_d   = frame_q;
            if (row_wrap && step) begin
                pending_d = 1'b0;
                if (!(mode == SEQ_ONESHOT && frame_q == LAST_FRAME)) begin
                    if (frame_q == LAST_FRAME) begin
                        frame_d = '0;
                    end else begin
                        frame_d   = frame_q + FW'(1);
                        reached_d = (mode == SEQ_ONESHOT) && (frame_q + FW'(1) == LAST_FRAME);
                    end
                end
            end
            row_n_d     = ~(ROWS'(1) << r_q);
            frame_idx_d = frame_q;
            seq_done_d  = reached_q;
`ifdef DMA_PWM_DIM_EN
            sub_d  = div_wrap ? sub_q + 4'd1 : sub_q;
            show_d = (sub_q < bright);
`else
            show_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            div_q       <= '0;
            tick_q      <= '0;
            frame_q     <= '0;
            pending_q   <= 1'b0;
            reached_q   <= 1'b0;
            row_n_q     <= ROW_IDLE_N[ROWS-1:0];
            show_q      <= 1'b0;
            frame_idx_q <= '0;
            seq_done_q  <= 1'b0;
`ifdef DMA_PWM_DIM_EN
            sub_q       <= '0;
`endif
        end else begin
            r_q         <= r_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
            frame_q     <= frame_d;
            pending_q   <= pending_d;
            reached_q   <= reached_d;
            row_n_q     <= row_n_d;
            show_q      <= show_d;
            frame_idx_q <= frame_idx_d;
            seq_done_q  <= seq_done_d;
`ifdef DMA_PWM_DIM_EN
            sub_q       <= sub_d;
`endif
        end
    end

    // Column data is the RAM read register, blanked by the registered slot enable.
    assign row_n     = row_n_q;
    assign col_red   = rd_data[2*COLS-1:COLS] & {COLS{show_q}};
    assign col_green = rd_data[COLS-1:0] & {COLS{show_q}};
    assign frame_idx = frame_idx_q;
    assign seq_done  = seq_done_q;

endmodule

// File: tb/tb_dot_matrix_anim.sv
// Self-checking bench for dot_matrix_anim: table vectors, a cycle-count reference model feeding a
// scoreboard queue, and hand-written sequences for frame stepping, oneshot, run drop and live writes.
module tb_dot_matrix_anim;

    localparam int ROWS = 8, COLS = 8, FRAMES = 4, SCAN_DIV = 2, FRAME_TICKS = 64;

    logic       clk = 1'b0, rst = 1'b1, run = 1'b0, advance = 1'b0, oneshot = 1'b0, wr_en = 1'b0;
    logic [1:0] wr_frame = '0;
    logic [2:0] wr_row = '0;
    logic [7:0] wr_red = '0, wr_green = '0;
    logic [7:0] row_n, col_red, col_green;
    logic [1:0] frame_idx;
    logic       seq_done;

    dot_matrix_anim #(
        .ROWS(ROWS), .COLS(COLS), .FRAMES(FRAMES), .SCAN_DIV(SCAN_DIV), .FRAME_TICKS(FRAME_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .advance(advance), .oneshot(oneshot),
        .wr_en(wr_en), .wr_frame(wr_frame), .wr_row(wr_row), .wr_red(wr_red), .wr_green(wr_green),
        .row_n(row_n), .col_red(col_red), .col_green(col_green),
        .frame_idx(frame_idx), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, run, advance, oneshot, wr_en;
        logic [1:0] wr_frame;
        logic [2:0] wr_row;
        logic [7:0] wr_red, wr_green;
    } stim_t;

    typedef struct {
        logic [7:0] row_n, red, green;
        logic [1:0] frame;
        logic       done;
    } out_t;

    typedef struct {
        stim_t s;
        out_t  e;
    } vec_t;

    out_t  exp_q[$];
    vec_t  vecs[19];
    stim_t cur;
    int    checks_total = 0;
    int    checks_passed = 0;

    // Reference model state: cycles since scanning (re)started, shown frame, pending step, RAM image.
    int         m_c = 0;
    int         m_frame = 0;
    bit         m_pend = 1'b0;
    bit         m_done = 1'b0;
    logic [7:0] m_red_l = '0, m_green_l = '0;
    logic [7:0] mem_red[32];
    logic [7:0] mem_green[32];

    function automatic stim_t mk_s(bit r, bit rn, bit adv, bit os, bit we, int f, int row,
                                   logic [7:0] red, logic [7:0] green);
        stim_t s;
        s.rst = r; s.run = rn; s.advance = adv; s.oneshot = os; s.wr_en = we;
        s.wr_frame = 2'(f); s.wr_row = 3'(row); s.wr_red = red; s.wr_green = green;
        return s;
    endfunction

    function automatic out_t mk_o(logic [7:0] rn, logic [7:0] red, logic [7:0] green, int f, bit d);
        out_t o;
        o.row_n = rn; o.red = red; o.green = green; o.frame = 2'(f); o.done = d;
        return o;
    endfunction

    // Rows are held SCAN_DIV cycles, column data is fetched at the start of each row slot,
    // ticks land every FRAME_TICKS cycles and frame steps only take effect on the last cycle of a scan.
    task automatic model_step(input stim_t s, output out_t e);
        if (s.rst || !s.run) begin
            e = mk_o(8'hFF, 8'h00, 8'h00, 0, 1'b0);
            m_c = 0; m_frame = 0; m_pend = 1'b0; m_done = 1'b0;
        end else begin
            int row;
            row = (m_c / SCAN_DIV) % ROWS;
            if (m_c % SCAN_DIV == 0) begin
                m_red_l   = mem_red[m_frame * ROWS + row];
                m_green_l = mem_green[m_frame * ROWS + row];
            end
            e = mk_o(~(8'h01 << row), m_red_l, m_green_l, m_frame, m_done);
            m_done = 1'b0;
            if ((m_c % FRAME_TICKS == FRAME_TICKS - 1) && s.advance) m_pend = 1'b1;
            if ((m_c % (SCAN_DIV * ROWS) == SCAN_DIV * ROWS - 1) && m_pend) begin
                m_pend = 1'b0;
                if (s.oneshot && m_frame == FRAMES - 1) begin
                    m_frame = m_frame;
                end else if (m_frame == FRAMES - 1) begin
                    m_frame = 0;
                end else begin
                    m_frame = m_frame + 1;
                    m_done  = s.oneshot && (m_frame == FRAMES - 1);
                end
            end
            m_c++;
        end
        if (s.wr_en) begin
            mem_red[int'(s.wr_frame) * ROWS + int'(s.wr_row)]   = s.wr_red;
            mem_green[int'(s.wr_frame) * ROWS + int'(s.wr_row)] = s.wr_green;
        end
    endtask

    task automatic applyStimulus(input stim_t s, input bit use_exp, input out_t exp_in);
        out_t m;
        rst = s.rst; run = s.run; advance = s.advance; oneshot = s.oneshot;
        wr_en = s.wr_en; wr_frame = s.wr_frame; wr_row = s.wr_row;
        wr_red = s.wr_red; wr_green = s.wr_green;
        model_step(s, m);
        if (use_exp) exp_q.push_back(exp_in);
        else         exp_q.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name);
        out_t e;
        checks_total++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL %s: scoreboard empty, nothing to compare against", name);
        end else begin
            e = exp_q.pop_front();
            if (row_n === e.row_n && col_red === e.red && col_green === e.green &&
                frame_idx === e.frame && seq_done === e.done) begin
                checks_passed++;
            end else begin
                $display("[TB] FAIL %s: got row_n=%h red=%h green=%h frame=%0d done=%b, expected row_n=%h red=%h green=%h frame=%0d done=%b",
                         name, row_n, col_red, col_green, frame_idx, seq_done,
                         e.row_n, e.red, e.green, e.frame, e.done);
            end
        end
    endtask

    task automatic step(input stim_t s, input string name);
        out_t none;
        none = mk_o(8'h00, 8'h00, 8'h00, 0, 1'b0);
        applyStimulus(s, 1'b0, none);
        checkOutput(name);
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        checks_total++;
        if (got === want) checks_passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    endtask

    initial begin
        logic [7:0] f0_red[8]   = '{8'h01, 8'h02, 8'h04, 8'h18, 8'h10, 8'h20, 8'h40, 8'h80};
        logic [7:0] f0_green[8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        logic [7:0] scan_rn[8]  = '{8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB, 8'hF7, 8'hF7};
        int         loop_seq[4] = '{1, 2, 3, 0};
        int         chg[$];
        logic [1:0] prev;
        int         done_cnt, at3, left3, n;
        bit         seen3;

        // Reset, load frame 0 while blanked, then the first half-scan with advance off.
        for (int k = 0; k < 3; k++) begin
            vecs[k].s = mk_s(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
            vecs[k].e = mk_o(8'hFF, 8'h00, 8'h00, 0, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            vecs[3 + k].s = mk_s(0, 0, 0, 0, 1, 0, k, f0_red[k], f0_green[k]);
            vecs[3 + k].e = mk_o(8'hFF, 8'h00, 8'h00, 0, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            vecs[11 + k].s = mk_s(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
            vecs[11 + k].e = mk_o(scan_rn[k], f0_red[k / 2], f0_green[k / 2], 0, 1'b0);
        end

        #2;
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].s, 1'b1, vecs[i].e);
            checkOutput($sformatf("vec%0d", i));
        end

        cur = mk_s(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 24; i++) step(cur, "scan_frozen");

        for (int f = 1; f < 4; f++)
            for (int r = 0; r < 8; r++)
                step(mk_s(0, 0, 0, 0, 1, f, r, 8'(f * 32 + r * 3 + 1), 8'(8'hF0 ^ (f * 16 + r))), "load");

        // Looping sequencer: every frame change must appear together with row 0.
        cur = mk_s(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
        prev = frame_idx;
        for (int i = 0; i < 300; i++) begin
            step(cur, "loop");
            if (frame_idx !== prev) begin
                check8("loop_change_row", row_n, 8'hFE);
                chg.push_back(int'(frame_idx));
                prev = frame_idx;
            end
        end
        check8("loop_change_count", 8'(chg.size()), 8'd4);
        for (int k = 0; k < 4; k++)
            check8("loop_seq", (k < chg.size()) ? 8'(chg[k]) : 8'hFF, 8'(loop_seq[k]));

        cur = mk_s(0, 1, 1, 1, 0, 0, 0, 8'h00, 8'h00);
        done_cnt = 0; at3 = 0; left3 = 0; seen3 = 1'b0;
        for (int i = 0; i < 1300; i++) begin
            step(cur, "oneshot");
            if (seq_done === 1'b1) begin
                done_cnt++;
                check8("done_frame", 8'(frame_idx), 8'd3);
            end
            if (frame_idx === 2'd3) begin
                seen3 = 1'b1;
                at3++;
            end else if (seen3) begin
                left3++;
            end
        end
        check8("done_pulses", 8'(done_cnt), 8'd1);
        check8("oneshot_left_last", 8'(left3), 8'd0);
        check8("oneshot_hold_1000", 8'(at3 >= 1000), 8'd1);

        // Restart, run into frame 2, then drop run mid-frame.
        step(mk_s(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00), "restart_blank");
        cur = mk_s(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
        n = 0;
        while (frame_idx !== 2'd2 && n < 400) begin
            step(cur, "to_frame2");
            n++;
        end
        check8("reach_frame2", 8'(frame_idx), 8'd2);
        for (int i = 0; i < 20; i++) step(cur, "mid_frame2");
        step(mk_s(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00), "run_drop");
        check8("drop_row_n", row_n, 8'hFF);
        check8("drop_red", col_red, 8'h00);
        check8("drop_frame", 8'(frame_idx), 8'd0);
        cur = mk_s(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        step(cur, "run_restart");
        check8("restart_row_n", row_n, 8'hFE);

        // Rewrite the row on display: old data for the rest of this slot, new data next scan.
        n = 0;
        while (row_n !== 8'hF7 && n < 32) begin
            step(cur, "seek_row3");
            n++;
        end
        check8("seek_row3", row_n, 8'hF7);
        step(mk_s(0, 1, 0, 0, 1, 0, 3, 8'h5A, 8'hC3), "live_write");
        check8("live_old_red", col_red, 8'h18);
        n = 0;
        while (row_n === 8'hF7 && n < 32) begin
            step(cur, "leave_row3");
            n++;
        end
        n = 0;
        while (row_n !== 8'hF7 && n < 32) begin
            step(cur, "next_row3");
            n++;
        end
        check8("live_new_red", col_red, 8'h5A);
        check8("live_new_green", col_green, 8'hC3);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
